// File: rtl/dnn2ami_wr_sequencer_if.sv
// rtl/dnn2ami_wr_sequencer_if.sv - AMI single-beat write port
interface dnn2ami_wr_sequencer_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    logic              ami_wr_valid;
    logic [ADDR_W-1:0] ami_wr_addr;
    logic [DATA_W-1:0] ami_wr_data;
    logic              ami_wr_last;
    logic              ami_wr_ready;

    modport master (
        output ami_wr_valid, ami_wr_addr, ami_wr_data, ami_wr_last,
        input  ami_wr_ready
    );

    modport slave (
        input  ami_wr_valid, ami_wr_addr, ami_wr_data, ami_wr_last,
        output ami_wr_ready
    );
endinterface

// File: rtl/dnn2ami_wr_sequencer.sv
// rtl/dnn2ami_wr_sequencer.sv - queues macro write requests and fractures them into single-beat AMI writes
module dnn2ami_wr_sequencer #(
    parameter int NUM_PU      = 2,
    parameter int PU_SEL_W    = 1,
    parameter int DATA_W      = 512,
    parameter int ADDR_W      = 64,
    parameter int SIZE_W      = 10,
    parameter int BEAT_BYTES  = 64,
    parameter int Q_LOG_DEPTH = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [SIZE_W-1:0]        wr_size,
    input  logic [PU_SEL_W-1:0]      wr_pu,
    output logic                     wr_req_ready,
    input  logic [NUM_PU-1:0]        outbuf_empty,
    input  logic [NUM_PU*DATA_W-1:0] outbuf_data,
    output logic [NUM_PU-1:0]        outbuf_pop,
    dnn2ami_wr_sequencer_if.master   ami,
    output logic                     macro_done,
    output logic                     err_bad_pu,
    output logic                     busy,
    output logic [Q_LOG_DEPTH:0]     reqs_pending
);
    localparam int DEPTH = 1 << Q_LOG_DEPTH;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [SIZE_W-1:0]   size;
        logic [PU_SEL_W-1:0] pu;
    } req_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    req_t                   q_mem [DEPTH];
    logic [Q_LOG_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [Q_LOG_DEPTH:0]   q_count;
    state_t                 state;
    logic [ADDR_W-1:0]      cur_addr;
    logic [SIZE_W-1:0]      beats_left;
    logic [PU_SEL_W-1:0]    cur_pu;
    logic                   enq, deq, load, sel_empty, head_bad;
    logic [DATA_W-1:0]      sel_data;
    req_t                   head;

    assign wr_req_ready = (q_count != (Q_LOG_DEPTH+1)'(DEPTH));
    assign enq          = wr_req && wr_req_ready;
    assign deq          = (state == IDLE) && (q_count != '0);
    assign head         = q_mem[rd_ptr];
    assign head_bad     = 32'(head.pu) >= NUM_PU;
    assign reqs_pending = q_count;
    assign busy         = (q_count != '0) || (state != IDLE) || ami.ami_wr_valid;

    // Out-of-range selects read as an empty channel so they can never load.
    always_comb begin
        sel_empty = 1'b1;
        sel_data  = '0;
        for (int k = 0; k < NUM_PU; k++) begin
            if (cur_pu == PU_SEL_W'(k)) begin
                sel_empty = outbuf_empty[k];
                sel_data  = outbuf_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign load = reset_n && (state == ISSUE) && (!ami.ami_wr_valid || ami.ami_wr_ready)
                  && !sel_empty && (beats_left != '0);

    always_comb begin
        outbuf_pop = '0;
        for (int k = 0; k < NUM_PU; k++) begin
            outbuf_pop[k] = load && (cur_pu == PU_SEL_W'(k));
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            q_mem[wr_ptr] <= '{addr: wr_addr, size: wr_size, pu: wr_pu};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            cur_addr         <= '0;
            beats_left       <= '0;
            cur_pu           <= '0;
            ami.ami_wr_valid <= 1'b0;
            ami.ami_wr_last  <= 1'b0;
            ami.ami_wr_addr  <= '0;
            ami.ami_wr_data  <= '0;
            macro_done       <= 1'b0;
            err_bad_pu       <= 1'b0;
        end else begin
            macro_done <= ami.ami_wr_valid && ami.ami_wr_ready && ami.ami_wr_last;
            case (state)
                IDLE: begin
                    if (deq) begin
                        cur_addr   <= head.addr;
                        beats_left <= head.size;
                        cur_pu     <= head.pu;
                        if (head_bad) err_bad_pu <= 1'b1;
                        // Zero-size and bad-PU requests retire here without issuing.
                        if ((head.size != '0) && !head_bad) state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (load && (beats_left == SIZE_W'(1))) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                ami.ami_wr_data  <= sel_data;
                ami.ami_wr_addr  <= cur_addr;
                ami.ami_wr_valid <= 1'b1;
                ami.ami_wr_last  <= (beats_left == SIZE_W'(1));
                cur_addr         <= cur_addr + ADDR_W'(BEAT_BYTES);
                beats_left       <= beats_left - 1'b1;
            end else if (ami.ami_wr_valid && ami.ami_wr_ready) begin
                ami.ami_wr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dnn2ami_wr_sequencer.sv
// tb/tb_dnn2ami_wr_sequencer.sv - scoreboard bench for dnn2ami_wr_sequencer
module tb_dnn2ami_wr_sequencer;
    localparam int NUM_PU = 2, PU_SEL_W = 2, DATA_W = 512, ADDR_W = 64;
    localparam int SIZE_W = 10, BEAT_BYTES = 64, Q_LOG_DEPTH = 3;

    logic                     clock, reset_n, wr_req, wr_req_ready;
    logic [ADDR_W-1:0]        wr_addr;
    logic [SIZE_W-1:0]        wr_size;
    logic [PU_SEL_W-1:0]      wr_pu;
    logic [NUM_PU-1:0]        outbuf_empty, outbuf_pop;
    logic [NUM_PU*DATA_W-1:0] outbuf_data;
    logic                     macro_done, err_bad_pu, busy;
    logic [Q_LOG_DEPTH:0]     reqs_pending;

    dnn2ami_wr_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ami ();

    dnn2ami_wr_sequencer #(
        .NUM_PU(NUM_PU), .PU_SEL_W(PU_SEL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .SIZE_W(SIZE_W), .BEAT_BYTES(BEAT_BYTES), .Q_LOG_DEPTH(Q_LOG_DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_size(wr_size), .wr_pu(wr_pu), .wr_req_ready(wr_req_ready),
        .outbuf_empty(outbuf_empty), .outbuf_data(outbuf_data), .outbuf_pop(outbuf_pop),
        .ami(ami.master), .macro_done(macro_done), .err_bad_pu(err_bad_pu),
        .busy(busy), .reqs_pending(reqs_pending)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                pu;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    int                errors = 0, checks = 0;
    int                head_seq[NUM_PU], exp_seq[NUM_PU], pop_cnt[NUM_PU], exp_pop[NUM_PU];
    int                done_cnt = 0, exp_done_cnt = 0, beats_seen = 0;
    logic              exp_done = 1'b0, prev_hold = 1'b0, prev_last;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] make_data(int pu, int seq);
        return {16{pu[15:0], seq[15:0]}};
    endfunction

    task automatic check(string tag, logic [DATA_W-1:0] obs, logic [DATA_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output-buffer model: an endless numbered stream per PU, advanced by pops.
    always_comb begin
        outbuf_data = '0;
        for (int k = 0; k < NUM_PU; k++) outbuf_data[k*DATA_W +: DATA_W] = make_data(k, head_seq[k]);
    end

    initial begin
        for (int k = 0; k < NUM_PU; k++) head_seq[k] = 0;
        forever begin
            @(posedge clock);
            for (int k = 0; k < NUM_PU; k++)
                if (outbuf_pop[k] && !outbuf_empty[k]) head_seq[k] <= head_seq[k] + 1;
        end
    end

    initial begin
        beat_t b;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (outbuf_pop != '0) begin
                    check("pop_onehot", $countones(outbuf_pop) <= 1, 1);
                    check("pop_nonempty", |(outbuf_pop & outbuf_empty), 0);
                    for (int k = 0; k < NUM_PU; k++) pop_cnt[k] += int'(outbuf_pop[k]);
                end
                if (exp_done || macro_done) check("macro_done", macro_done, exp_done);
                if (macro_done) done_cnt++;
                if (prev_hold) begin
                    check("hold_valid", ami.ami_wr_valid, 1);
                    check("hold_addr", ami.ami_wr_addr, prev_addr);
                    check("hold_data", ami.ami_wr_data, prev_data);
                    check("hold_last", ami.ami_wr_last, prev_last);
                end
                exp_done = ami.ami_wr_valid && ami.ami_wr_ready && ami.ami_wr_last;
                if (ami.ami_wr_valid && ami.ami_wr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_addr", ami.ami_wr_addr, b.addr);
                        check("beat_data", ami.ami_wr_data, make_data(b.pu, exp_seq[b.pu]));
                        check("beat_last", ami.ami_wr_last, b.last);
                        exp_seq[b.pu]++;
                    end
                    beats_seen++;
                end
                prev_hold = ami.ami_wr_valid && !ami.ami_wr_ready;
                prev_addr = ami.ami_wr_addr;
                prev_data = ami.ami_wr_data;
                prev_last = ami.ami_wr_last;
            end else begin
                exp_done  = 1'b0;
                prev_hold = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic submit(logic [ADDR_W-1:0] addr, int size, int pu, logic exp_rdy);
        beat_t b;
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_size = SIZE_W'(size);
        wr_pu   = PU_SEL_W'(pu);
        check("wr_req_ready", wr_req_ready, exp_rdy);
        if (exp_rdy && size != 0 && pu < NUM_PU) begin
            for (int i = 0; i < size; i++) begin
                b.addr = addr + ADDR_W'(i * BEAT_BYTES);
                b.pu   = pu;
                b.last = (i == size - 1);
                exp_q.push_back(b);
            end
            exp_pop[pu] += size;
            exp_done_cnt++;
        end
        tick();
        wr_req = 1'b0;
    endtask

    task automatic start_test();
        for (int k = 0; k < NUM_PU; k++) begin
            pop_cnt[k] = 0;
            exp_pop[k] = 0;
        end
        done_cnt     = 0;
        exp_done_cnt = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", n < 200, 1);
    endtask

    task automatic end_test(string name);
        tick();
        tick();
        for (int k = 0; k < NUM_PU; k++) check({name, "_pops"}, pop_cnt[k], exp_pop[k]);
        check({name, "_macro_done_cnt"}, done_cnt, exp_done_cnt);
    endtask

    task automatic wait_beat(logic [ADDR_W-1:0] addr);
        int n = 0;
        while (!(ami.ami_wr_valid && ami.ami_wr_addr == addr) && n < 100) begin
            tick();
            n++;
        end
        check("wait_beat_timeout", n < 100, 1);
    endtask

    task automatic check_reset();
        check("rst_valid", ami.ami_wr_valid, 0);
        check("rst_last", ami.ami_wr_last, 0);
        check("rst_addr", ami.ami_wr_addr, 0);
        check("rst_data", ami.ami_wr_data, 0);
        check("rst_macro_done", macro_done, 0);
        check("rst_err_bad_pu", err_bad_pu, 0);
        check("rst_pop", outbuf_pop, 0);
        check("rst_pending", reqs_pending, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", wr_req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        for (int k = 0; k < NUM_PU; k++) exp_seq[k] = 0;
        reset_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_size = '0; wr_pu = '0;
        outbuf_empty = '0; ami.ami_wr_ready = 1'b1;
        repeat (3) tick();
        check_reset();
        reset_n = 1'b1;
        tick();

        // Single request, plus first-beat latency.
        start_test();
        submit(64'h1000, 4, 1, 1);
        check("lat_n", ami.ami_wr_valid, 0);
        tick();
        check("lat_n1", ami.ami_wr_valid, 0);
        tick();
        check("lat_n2_valid", ami.ami_wr_valid, 1);
        check("lat_n2_addr", ami.ami_wr_addr, 64'h1000);
        wait_drain();
        end_test("single");

        // Backpressure on beat 2.
        start_test();
        submit(64'h1000, 4, 1, 1);
        wait_beat(64'h1040);
        ami.ami_wr_ready = 1'b0;
        repeat (3) tick();
        ami.ami_wr_ready = 1'b1;
        wait_drain();
        end_test("backpressure");

        // FIFO full: the head request is stuck holding a beat, eight more fill the queue.
        start_test();
        ami.ami_wr_ready = 1'b0;
        for (int i = 0; i < 9; i++) submit(64'h20000 + 64'(i * 'h1000), 2, i % 2, 1);
        submit(64'h90000, 2, 0, 0);
        check("full_pending", reqs_pending, 8);
        check("full_ready", wr_req_ready, 0);
        ami.ami_wr_ready = 1'b1;
        wait_drain();
        end_test("fifo_full");

        // Zero-size, bad PU, then a normal request.
        start_test();
        submit(64'h3000, 0, 0, 1);
        submit(64'h4000, 2, 3, 1);
        submit(64'h5000, 2, 0, 1);
        wait_drain();
        end_test("zero_bad");
        check("err_bad_pu", err_bad_pu, 1);

        // Outbuf starvation mid-request.
        start_test();
        submit(64'h6000, 3, 0, 1);
        wait_beat(64'h6000);
        outbuf_empty[0] = 1'b1;
        repeat (3) tick();
        check("starve_valid", ami.ami_wr_valid, 0);
        tick();
        outbuf_empty[0] = 1'b0;
        wait_drain();
        end_test("starve");

        // Reset mid-request with requests still queued.
        start_test();
        base = beats_seen;
        submit(64'h7000, 6, 1, 1);
        submit(64'h8000, 2, 0, 1);
        submit(64'h9000, 2, 0, 1);
        begin
            int n = 0;
            while (beats_seen < base + 2 && n < 100) begin
                tick();
                n++;
            end
            check("reset_wait_timeout", n < 100, 1);
        end
        reset_n = 1'b0;
        tick();
        tick();
        check_reset();
        exp_q.delete();
        for (int k = 0; k < NUM_PU; k++) exp_seq[k] = head_seq[k];
        reset_n = 1'b1;
        tick();
        start_test();
        submit(64'hA000, 2, 1, 1);
        wait_drain();
        end_test("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
